// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module  : multicycle_ctrl
// Brief   : Multicycle RV64-subset control FSM with timed memory handshakes,
//           illegal-op trap and retired-instruction counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             alu_zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             load_ir,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_op,
    output logic             aluout_write,
    output logic             imem_req,
    output logic             dmem_rd_req,
    output logic             dmem_wr_req,
    output logic             mdr_write,
    output logic             rf_write,
    output logic [1:0]       rf_wsel,
    output logic             illegal,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] instret
);

    localparam int c_to_w = $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_WB_ALU = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_WB_MEM = 4'd7,
        S_MEM_WR = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_LUI    = 4'd11,
        S_RETIRE = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_to_w-1:0]   r_cnt;
    logic [1:0]          r_err;
    logic [1:0]          w_trap_err;
    logic [CNT_W-1:0]    r_instret;
    logic                w_timeout;
    logic                w_wait_state;
    logic [3:0]          w_fn_op;
    logic                w_fn_ok;

    assign w_timeout    = (r_cnt == c_to_w'(MEM_TIMEOUT - 1));
    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);

    // funct7_5 only selects sub for register-register add; immediates have no subi
    always_comb begin
        w_fn_op = 4'd0;
        w_fn_ok = 1'b1;
        case (funct3)
            3'b000:  w_fn_op = (funct7_5 && r_state == S_EXEC_R) ? 4'd1 : 4'd0;
            3'b111:  w_fn_op = 4'd2;
            3'b110:  w_fn_op = 4'd3;
            3'b100:  w_fn_op = 4'd4;
            3'b010:  w_fn_op = 4'd5;
            default: w_fn_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_err     <= 2'd0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == S_TRAP && r_state != S_TRAP) begin
                r_err <= w_trap_err;
            end
            if (r_state == S_RETIRE) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_wait_state) begin
                r_cnt <= r_cnt + c_to_w'(1);
            end
        end
    end

    // While reset is held every output is forced low, including the FETCH request
    always_comb begin
        w_next       = r_state;
        w_trap_err   = 2'd0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        load_ir      = 1'b0;
        alu_src_a    = 2'd0;
        alu_src_b    = 2'd0;
        alu_op       = 4'd0;
        aluout_write = 1'b0;
        imem_req     = 1'b0;
        dmem_rd_req  = 1'b0;
        dmem_wr_req  = 1'b0;
        mdr_write    = 1'b0;
        rf_write     = 1'b0;
        rf_wsel      = 2'd0;
        illegal      = 1'b0;
        err_code     = 2'd0;
        instret      = '0;
        if (!reset) begin
            instret = r_instret;
            case (r_state)
                S_FETCH: begin
                    imem_req  = 1'b1;
                    alu_src_b = 2'd1;
                    load_ir   = imem_ready;
                    pc_write  = imem_ready;
                    if (imem_ready) begin
                        w_next = S_DECODE;
                    end else if (w_timeout) begin
                        w_next     = S_TRAP;
                        w_trap_err = 2'd2;
                    end
                end
                S_DECODE: begin
                    alu_src_a    = 2'd2;
                    alu_src_b    = 2'd2;
                    aluout_write = 1'b1;
                    case (opcode)
                        c_OP_R:      w_next = S_EXEC_R;
                        c_OP_I:      w_next = S_EXEC_I;
                        c_OP_LOAD:   w_next = S_ADDR;
                        c_OP_STORE:  w_next = S_ADDR;
                        c_OP_BRANCH: w_next = S_BRANCH;
                        c_OP_JAL:    w_next = S_JAL;
                        c_OP_LUI:    w_next = S_LUI;
                        default: begin
                            w_next     = S_TRAP;
                            w_trap_err = 2'd1;
                        end
                    endcase
                end
                S_EXEC_R, S_EXEC_I: begin
                    alu_src_a = 2'd1;
                    alu_src_b = (r_state == S_EXEC_I) ? 2'd2 : 2'd0;
                    if (w_fn_ok) begin
                        alu_op       = w_fn_op;
                        aluout_write = 1'b1;
                        w_next       = S_WB_ALU;
                    end else begin
                        w_next     = S_TRAP;
                        w_trap_err = 2'd1;
                    end
                end
                S_WB_ALU: begin
                    rf_write = 1'b1;
                    w_next   = S_RETIRE;
                end
                S_ADDR: begin
                    alu_src_a    = 2'd1;
                    alu_src_b    = 2'd2;
                    aluout_write = 1'b1;
                    w_next       = (opcode == c_OP_LOAD) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    dmem_rd_req = 1'b1;
                    mdr_write   = dmem_ready;
                    if (dmem_ready) begin
                        w_next = S_WB_MEM;
                    end else if (w_timeout) begin
                        w_next     = S_TRAP;
                        w_trap_err = 2'd3;
                    end
                end
                S_WB_MEM: begin
                    rf_write = 1'b1;
                    rf_wsel  = 2'd1;
                    w_next   = S_RETIRE;
                end
                S_MEM_WR: begin
                    dmem_wr_req = 1'b1;
                    if (dmem_ready) begin
                        w_next = S_RETIRE;
                    end else if (w_timeout) begin
                        w_next     = S_TRAP;
                        w_trap_err = 2'd3;
                    end
                end
                S_BRANCH: begin
                    alu_src_a = 2'd1;
                    alu_op    = 4'd1;
                    pc_src    = 1'b1;
                    case (funct3)
                        3'b000: begin
                            pc_write = alu_zero;
                            w_next   = S_RETIRE;
                        end
                        3'b001: begin
                            pc_write = !alu_zero;
                            w_next   = S_RETIRE;
                        end
                        default: begin
                            w_next     = S_TRAP;
                            w_trap_err = 2'd1;
                        end
                    endcase
                end
                S_JAL: begin
                    rf_write = 1'b1;
                    rf_wsel  = 2'd2;
                    pc_write = 1'b1;
                    pc_src   = 1'b1;
                    w_next   = S_RETIRE;
                end
                S_LUI: begin
                    alu_src_a    = 2'd3;
                    alu_src_b    = 2'd2;
                    aluout_write = 1'b1;
                    w_next       = S_WB_ALU;
                end
                S_RETIRE: begin
                    w_next = S_FETCH;
                end
                S_TRAP: begin
                    illegal  = 1'b1;
                    err_code = r_err;
                end
                default: begin
                    w_next = S_FETCH;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module  : tb_multicycle_ctrl
// Brief   : Self-checking bench for multicycle_ctrl: instruction vector table
//           plus handshake, timeout, trap and counter-wrap sequences.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'h13;
    logic [2:0]  funct3 = 3'd0;
    logic        funct7_5 = 1'b0;
    logic        alu_zero = 1'b0;
    logic        imem_ready = 1'b1;
    logic        dmem_ready = 1'b1;

    logic        pc_write, pc_src, load_ir, aluout_write, imem_req;
    logic        dmem_rd_req, dmem_wr_req, mdr_write, rf_write, illegal;
    logic [1:0]  alu_src_a, alu_src_b, rf_wsel, err_code;
    logic [3:0]  alu_op;
    logic [31:0] instret;

    logic        b_pc_write, b_pc_src, b_load_ir, b_aluout_write, b_imem_req;
    logic        b_dmem_rd_req, b_dmem_wr_req, b_mdr_write, b_rf_write, b_illegal;
    logic [1:0]  b_alu_src_a, b_alu_src_b, b_rf_wsel, b_err_code;
    logic [3:0]  b_alu_op;
    logic [1:0]  b_instret;

    logic [21:0] all_outs;
    assign all_outs = {pc_write, pc_src, load_ir, alu_src_a, alu_src_b, alu_op, aluout_write,
                       imem_req, dmem_rd_req, dmem_wr_req, mdr_write, rf_write, rf_wsel,
                       illegal, err_code};

    multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .alu_zero(alu_zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .load_ir(load_ir), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .aluout_write(aluout_write),
        .imem_req(imem_req), .dmem_rd_req(dmem_rd_req), .dmem_wr_req(dmem_wr_req),
        .mdr_write(mdr_write), .rf_write(rf_write), .rf_wsel(rf_wsel), .illegal(illegal),
        .err_code(err_code), .instret(instret)
    );

    // Narrow counter instance to exercise wrap-around in a handful of instructions
    multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(2)) dut_wrap (
        .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .alu_zero(alu_zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .pc_write(b_pc_write), .pc_src(b_pc_src), .load_ir(b_load_ir), .alu_src_a(b_alu_src_a),
        .alu_src_b(b_alu_src_b), .alu_op(b_alu_op), .aluout_write(b_aluout_write),
        .imem_req(b_imem_req), .dmem_rd_req(b_dmem_rd_req), .dmem_wr_req(b_dmem_wr_req),
        .mdr_write(b_mdr_write), .rf_write(b_rf_write), .rf_wsel(b_rf_wsel), .illegal(b_illegal),
        .err_code(b_err_code), .instret(b_instret)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [6:0] opc;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        logic [3:0] op3;
        logic       pcw3;
        int         evt;
        logic [1:0] err;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // Leaves the bench 1 time unit into the first FETCH cycle after reset
    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int evt, rd_cnt, mdr_c, req_cnt;
        logic [3:0] got_op;
        logic       got_pcw;
        logic [1:0] got_err;

        //             name      opc    f3  f7 zero op3 pcw evt err
        vecs[0]  = '{"addi",   7'h13, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 6, 2'd0};
        vecs[1]  = '{"add",    7'h33, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 6, 2'd0};
        vecs[2]  = '{"sub",    7'h33, 3'd0, 1'b1, 1'b0, 4'd1, 1'b0, 6, 2'd0};
        vecs[3]  = '{"and",    7'h33, 3'd7, 1'b0, 1'b0, 4'd2, 1'b0, 6, 2'd0};
        vecs[4]  = '{"or",     7'h33, 3'd6, 1'b0, 1'b0, 4'd3, 1'b0, 6, 2'd0};
        vecs[5]  = '{"xor",    7'h33, 3'd4, 1'b0, 1'b0, 4'd4, 1'b0, 6, 2'd0};
        vecs[6]  = '{"slt",    7'h33, 3'd2, 1'b0, 1'b0, 4'd5, 1'b0, 6, 2'd0};
        vecs[7]  = '{"andi",   7'h13, 3'd7, 1'b1, 1'b0, 4'd2, 1'b0, 6, 2'd0};
        vecs[8]  = '{"r_bad",  7'h33, 3'd1, 1'b0, 1'b0, 4'd0, 1'b0, 4, 2'd1};
        vecs[9]  = '{"i_bad",  7'h13, 3'd5, 1'b0, 1'b0, 4'd0, 1'b0, 4, 2'd1};
        vecs[10] = '{"lui",    7'h37, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 6, 2'd0};
        vecs[11] = '{"jal",    7'h6F, 3'd0, 1'b0, 1'b0, 4'd0, 1'b1, 5, 2'd0};
        vecs[12] = '{"beq_t",  7'h63, 3'd0, 1'b0, 1'b1, 4'd1, 1'b1, 5, 2'd0};
        vecs[13] = '{"beq_n",  7'h63, 3'd0, 1'b0, 1'b0, 4'd1, 1'b0, 5, 2'd0};
        vecs[14] = '{"bne_t",  7'h63, 3'd1, 1'b0, 1'b0, 4'd1, 1'b1, 5, 2'd0};
        vecs[15] = '{"bne_n",  7'h63, 3'd1, 1'b0, 1'b1, 4'd1, 1'b0, 5, 2'd0};
        vecs[16] = '{"b_bad",  7'h63, 3'd4, 1'b0, 1'b1, 4'd1, 1'b0, 4, 2'd1};
        vecs[17] = '{"ld",     7'h03, 3'd3, 1'b0, 1'b0, 4'd0, 1'b0, 7, 2'd0};
        vecs[18] = '{"sd",     7'h23, 3'd3, 1'b0, 1'b0, 4'd0, 1'b0, 6, 2'd0};
        vecs[19] = '{"op7f",   7'h7F, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 3, 2'd1};

        // Reset state held 3 cycles, then addi x1,x0,5 cycle by cycle
        opcode = 7'h13; funct3 = 3'd0; funct7_5 = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk("reset_outs", 32'(all_outs), 32'd0);
            chk("reset_instret", instret, 32'd0);
        end
        reset = 1'b0; #1;
        chk("c1_load_ir", 32'(load_ir), 32'd1);
        chk("c1_pc_write", 32'(pc_write), 32'd1);
        chk("c1_imem_req", 32'(imem_req), 32'd1);
        chk("c1_src_b", 32'(alu_src_b), 32'd1);
        step(); #1;
        chk("c2_decode_src", 32'({alu_src_a, alu_src_b, aluout_write, imem_req}), 32'b10_10_1_0);
        step(); #1;
        chk("c3_exec_i", 32'({alu_src_a, alu_src_b, alu_op, aluout_write}), 32'b01_10_0000_1);
        step(); #1;
        chk("c4_wb_alu", 32'({rf_write, rf_wsel}), 32'b1_00);
        step(); #1;
        chk("c5_retire_outs", 32'(all_outs), 32'd0);
        chk("c5_instret", instret, 32'd0);
        step(); #1;
        chk("c6_instret", instret, 32'd1);
        chk("c6_load_ir", 32'(load_ir), 32'd1);

        // Instruction table, all memories ready on first request
        for (int i = 0; i < NV; i++) begin
            opcode = vecs[i].opc; funct3 = vecs[i].f3;
            funct7_5 = vecs[i].f7; alu_zero = vecs[i].zero;
            imem_ready = 1'b1; dmem_ready = 1'b1;
            apply_reset();
            evt = 0; got_op = 4'hF; got_pcw = 1'bx; got_err = 2'd0;
            for (int c = 1; c <= 20; c++) begin
                if (c > 1) begin
                    step(); #1;
                end
                if (c == 3) begin
                    got_op  = alu_op;
                    got_pcw = pc_write;
                end
                if (instret != 32'd0 || illegal) begin
                    evt     = c;
                    got_err = err_code;
                    break;
                end
            end
            chk({vecs[i].name, "_alu_op"}, 32'(got_op), 32'(vecs[i].op3));
            chk({vecs[i].name, "_pc_write"}, 32'(got_pcw), 32'(vecs[i].pcw3));
            chk({vecs[i].name, "_event_cycle"}, 32'(evt), 32'(vecs[i].evt));
            chk({vecs[i].name, "_err_code"}, 32'(got_err), 32'(vecs[i].err));
        end

        // Load with dmem_ready low for three wait cycles
        opcode = 7'h03; funct3 = 3'd3; dmem_ready = 1'b0; imem_ready = 1'b1;
        apply_reset();
        rd_cnt = 0; mdr_c = 0;
        for (int c = 2; c <= 8; c++) begin
            step();
            dmem_ready = (c == 7);
            #1;
            rd_cnt += int'(dmem_rd_req);
            if (mdr_write) mdr_c = c;
            if (c == 8) chk("ld_wb_mem", 32'({rf_write, rf_wsel}), 32'b1_01);
        end
        chk("ld_rd_req_cycles", 32'(rd_cnt), 32'd4);
        chk("ld_mdr_cycle", 32'(mdr_c), 32'd7);
        step(); step(); #1;
        chk("ld_instret", instret, 32'd1);

        // imem never ready: trap with err 2 after 16 wait cycles
        opcode = 7'h13; funct3 = 3'd0; imem_ready = 1'b0; dmem_ready = 1'b1;
        apply_reset();
        req_cnt = int'(imem_req);
        for (int c = 2; c <= 17; c++) begin
            step(); #1;
            req_cnt += int'(imem_req);
            if (c == 16) chk("ito_c16_illegal", 32'(illegal), 32'd0);
        end
        chk("ito_req_cycles", 32'(req_cnt), 32'd16);
        chk("ito_illegal", 32'(illegal), 32'd1);
        chk("ito_err_code", 32'(err_code), 32'd2);

        // imem ready exactly on the 16th wait cycle: no trap
        imem_ready = 1'b0;
        apply_reset();
        for (int c = 2; c <= 16; c++) begin
            step();
            if (c == 16) imem_ready = 1'b1;
            #1;
        end
        chk("ito_edge_load_ir", 32'(load_ir), 32'd1);
        step(); #1;
        chk("ito_edge_illegal", 32'(illegal), 32'd0);
        chk("ito_edge_decode", 32'(aluout_write), 32'd1);

        // Illegal opcode stays trapped until reset
        opcode = 7'h7F; imem_ready = 1'b1;
        apply_reset();
        step(); step(); #1;
        chk("op7f_err", 32'({illegal, err_code}), 32'b1_01);
        opcode = 7'h13;
        for (int c = 0; c < 5; c++) begin
            step();
            imem_ready = c[0];
            #1;
        end
        chk("sticky_trap", 32'({illegal, err_code, imem_req, instret[0]}), 32'b1_01_0_0);
        reset = 1'b1;
        step(); #1;
        chk("sticky_cleared", 32'(illegal), 32'd0);

        // dmem never accepts a store: trap with err 3
        opcode = 7'h23; funct3 = 3'd3; imem_ready = 1'b1; dmem_ready = 1'b0;
        apply_reset();
        for (int c = 2; c <= 20; c++) begin
            step(); #1;
            if (c == 19) chk("dto_c19", 32'({dmem_wr_req, illegal}), 32'b1_0);
        end
        chk("dto_trap", 32'({illegal, err_code, dmem_wr_req}), 32'b1_11_0);

        // Reset during MEM_WR after one retired instruction
        opcode = 7'h13; funct3 = 3'd0; dmem_ready = 1'b1;
        apply_reset();
        repeat (5) step();
        #1;
        chk("rst_pre_instret", instret, 32'd1);
        opcode = 7'h23; dmem_ready = 1'b0;
        repeat (3) step();
        #1;
        chk("rst_in_mem_wr", 32'(dmem_wr_req), 32'd1);
        reset = 1'b1; #1;
        chk("rst_held_outs", 32'(all_outs), 32'd0);
        step();
        reset = 1'b0; #1;
        chk("rst_wr_req_dropped", 32'({dmem_wr_req, imem_req}), 32'b0_1);
        chk("rst_instret_cleared", instret, 32'd0);

        // Counter wrap on the 2-bit instance
        opcode = 7'h13; dmem_ready = 1'b1;
        apply_reset();
        repeat (15) step();
        #1;
        chk("wrap_main_3", instret, 32'd3);
        chk("wrap_narrow_3", 32'(b_instret), 32'd3);
        repeat (5) step();
        #1;
        chk("wrap_main_4", instret, 32'd4);
        chk("wrap_narrow_0", 32'(b_instret), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
